// File: rtl/alu_exec.sv
// alu_exec: two-stage valid/ready ALU pipeline.
// Stage A registers the request (s, a, b); the ALU evaluates combinationally
// from stage A and the outcome is captured in stage B, which drives the outputs.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_SUB = 3'd1;
    localparam logic [2:0] SEL_AND = 3'd2;
    localparam logic [2:0] SEL_OR  = 3'd3;
    localparam logic [2:0] SEL_XOR = 3'd4;
    localparam logic [2:0] SEL_NOR = 3'd5;
    localparam logic [2:0] SEL_SLT = 3'd6;

    // Signed overflow of a + b: operands share a sign the sum does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y: operand signs differ and result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Stage A: registered request
    logic             r_a_valid;
    logic [2:0]       r_a_s;
    logic [WIDTH-1:0] r_a_a;
    logic [WIDTH-1:0] r_a_b;

    // Stage B: registered result bundle
    logic             r_b_valid;
    logic [WIDTH-1:0] r_b_result;
    logic             r_b_zero;
    logic             r_b_ovf;
    logic             r_b_illegal;

    // Combinational ALU outcome from stage A
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_illegal;
    logic             w_a_adv;
    logic             w_accept;

    assign w_sum    = r_a_a + r_a_b;
    assign w_diff   = r_a_a - r_a_b;

    // Stage A moves into B when B is empty or B is draining this cycle.
    assign w_a_adv  = r_a_valid && (!r_b_valid || out_ready);
    assign in_ready = !r_a_valid || w_a_adv;
    assign w_accept = in_valid && in_ready;

    // ALU operation select; reserved select yields a zero result flagged illegal.
    always_comb begin
        w_result  = {WIDTH{1'b0}};
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (r_a_s)
            SEL_ADD: begin
                w_result = w_sum;
                w_ovf    = add_ovf(r_a_a, r_a_b, w_sum);
            end
            SEL_SUB: begin
                w_result = w_diff;
                w_ovf    = sub_ovf(r_a_a, r_a_b, w_diff);
            end
            SEL_AND: w_result = r_a_a & r_a_b;
            SEL_OR:  w_result = r_a_a | r_a_b;
            SEL_XOR: w_result = r_a_a ^ r_a_b;
            SEL_NOR: w_result = ~(r_a_a | r_a_b);
            SEL_SLT: begin
                if ($signed(r_a_a) < $signed(r_a_b)) begin
                    w_result = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    w_result = {WIDTH{1'b0}};
                end
            end
            default: begin
                w_result  = {WIDTH{1'b0}};
                w_illegal = 1'b1;
            end
        endcase
    end

    // Stage A register: capture a new request, or empty once it has advanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_s     <= 3'd0;
            r_a_a     <= {WIDTH{1'b0}};
            r_a_b     <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_s     <= s;
            r_a_a     <= a;
            r_a_b     <= b;
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B register: load ALU outcome on advance, hold while stalled, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid   <= 1'b0;
            r_b_result  <= {WIDTH{1'b0}};
            r_b_zero    <= 1'b0;
            r_b_ovf     <= 1'b0;
            r_b_illegal <= 1'b0;
        end else if (w_a_adv) begin
            r_b_valid   <= 1'b1;
            r_b_result  <= w_result;
            r_b_zero    <= (w_result == {WIDTH{1'b0}});
            r_b_ovf     <= w_ovf;
            r_b_illegal <= w_illegal;
        end else if (out_ready) begin
            r_b_valid   <= 1'b0;
        end
    end

    assign out_valid = r_b_valid;
    assign result    = r_b_result;
    assign zero      = r_b_zero;
    assign ovf       = r_b_ovf;
    assign illegal   = r_b_illegal;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request present on s, a, b.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 s  input  3  ALU select from the ALU control decoder: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 reserved.
REQ-007 a  input  WIDTH  operand A (rs).
REQ-008 b  input  WIDTH  operand B (rt or extended immediate).
REQ-009 out_valid  output  1  result bundle present.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 ovf  output  1  signed overflow (add/sub only).
REQ-014 illegal  output  1  request carried reserved select 7.

Function
REQ-015 Request transfer SHALL occur on a rising clk edge where in_valid && in_ready; result transfer where out_valid && out_ready.
REQ-016 Block SHALL be a two-stage pipeline: stage A (input register: s, a, b, valid) and stage B (output register: result, zero, ovf, illegal, valid).
REQ-017 Stage A SHALL advance into stage B when A valid and (B empty or out_ready); ALU computation is combinational from stage A into stage B.
REQ-018 in_ready SHALL be high when stage A empty or stage A advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 Latency SHALL be 2: request accepted at edge k appears with out_valid high in the cycle following edge k+1 when out_ready held high.
REQ-020 Throughput SHALL be one operation per cycle with out_ready continuously high.
REQ-021 With out_ready low and both stages full, in_ready SHALL be low; no request SHALL be dropped or duplicated.
REQ-022 While out_valid && !out_ready, result, zero, ovf, illegal SHALL hold stable.
REQ-023 Results SHALL emerge in acceptance order.
REQ-024 add/sub SHALL be modulo 2^WIDTH; ovf = operand signs equal (add) / differ (sub) and result sign differs from a.
REQ-025 and/or/xor/nor SHALL be bitwise; ovf = 0.
REQ-026 slt SHALL compare a, b as signed two's complement; result = 1 if a < b else 0, zero-extended; ovf = 0.
REQ-027 s = 7 SHALL produce result 0, zero 1, ovf 0, illegal 1; pipeline flow unaffected.
REQ-028 illegal SHALL be 0 for s = 0..6.
REQ-029 Simultaneous output drain and input accept on a full pipeline SHALL proceed without a bubble.

Reset
REQ-030 rst_n low SHALL immediately clear both stage valid bits; out_valid = 0, result = 0, zero = 0, ovf = 0, illegal = 0.
REQ-031 in_ready SHALL be 1 throughout and after reset (empty pipeline).
REQ-032 Reset mid-operation SHALL discard all in-flight operations; no result for them SHALL ever appear.
REQ-033 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-034 add: s=0, a=0x7FFFFFFF, b=1, out_ready=1 -> two cycles later result=0x80000000, ovf=1, zero=0.
REQ-035 sub: s=1, a=5, b=5 -> result=0, zero=1, ovf=0; slt: s=6, a=0xFFFFFFFF, b=1 -> result=1.
REQ-036 Backpressure: out_ready=0, issue 3 back-to-back requests -> two accepted, in_ready low at third, result of first held stable; raise out_ready -> all three emerge in order, none lost.
REQ-037 Streaming: 16 random requests back-to-back, out_ready=1 -> 16 results on consecutive cycles matching a reference model.
REQ-038 Reserved: s=7, a=0x1234, b=0x5678 -> result=0, zero=1, illegal=1, ovf=0.
REQ-039 Reset mid-flight: both stages full, pulse rst_n low asynchronously -> out_valid drops without clock edge, no stale result after release.
